fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the FIFO data memory. It takes push/pop requests from the producer and consumer, generates `write_addr`/`read_addr` and `write_enable`/`read_enable` for the synchronous memory, and tracks occupancy. It reports full, empty, programmable almost-full and almost-empty flags, and sticky overflow/underflow errors. It also raises `data_valid` to mark the cycle when the memory's registered `Fifo_Data_out` holds the popped word.

## Interface
- `MEM_LENGHT`, default 8: number of memory entries. Must satisfy 2 ≤ `MEM_LENGHT` ≤ 2^`ADDR_WIDTH` − 1.
- `ADDR_WIDTH`, default 4: width of the address, count and threshold buses. Matches the memory's 4-bit address ports.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `push` in 1: producer request to write this cycle.
- `pop` in 1: consumer request to read this cycle.
- `umbral_alto` in `ADDR_WIDTH`: almost-full threshold.
- `umbral_bajo` in `ADDR_WIDTH`: almost-empty threshold.
- `write_enable` out 1: to memory; accepted push.
- `read_enable` out 1: to memory; accepted pop.
- `write_addr` out `ADDR_WIDTH`: to memory; write pointer.
- `read_addr` out `ADDR_WIDTH`: to memory; read pointer.
- `fifo_count` out `ADDR_WIDTH`: number of stored words, 0..`MEM_LENGHT`.
- `full`, `empty`, `almost_full`, `almost_empty` out 1: status flags.
- `overflow`, `underflow` out 1: sticky error flags.
- `data_valid` out 1: memory output holds the popped word this cycle.

## Operation
- Acceptance (combinational):
  - `write_enable` = `push` & ~`full`.
  - `read_enable` = `pop` & ~`empty`.
  - The flags come from registered `fifo_count`, so there is no combinational path from push/pop to any flag.
- Pointers (registered): `write_addr` increments on `write_enable`; `read_addr` increments on `read_enable`. Each pointer wraps from `MEM_LENGHT`−1 to 0 explicitly, with no reliance on power-of-two wrap.
- Count update:
  - +1 on `write_enable` only.
  - −1 on `read_enable` only.
  - Unchanged when both or neither are asserted.
- Flags:
  - `full` = (`fifo_count` == `MEM_LENGHT`).
  - `empty` = (`fifo_count` == 0).
  - `almost_full` = (`fifo_count` ≥ `umbral_alto`).
  - `almost_empty` = (`fifo_count` ≤ `umbral_bajo`).
  - Thresholds are sampled live, with no internal copy.
- Errors:
  - `overflow` sets on `push` & `full`.
  - `underflow` sets on `pop` & `empty`.
  - Both remain set until `reset`. A rejected request changes no pointer or count.
- `data_valid`: register of `read_enable`, asserted the cycle after an accepted pop.
- Simultaneous push & pop:
  - When empty: push accepted, pop rejected, `underflow` set, count → 1.
  - When full: pop accepted, push rejected, `overflow` set, count → `MEM_LENGHT`−1.
  - Otherwise both are accepted and the count holds.

## Timing
- Reset values:
  - `write_addr` = `read_addr` = 0, `fifo_count` = 0.
  - `empty` = 1, `full` = 0.
  - `overflow` = `underflow` = 0, `data_valid` = 0.
  - `almost_empty` = 1 if `umbral_bajo` ≥ 0 (always). `almost_full` = 1 only if `umbral_alto` = 0.
  - `write_enable` = `read_enable` = 0 while `reset` is high, regardless of `push`/`pop`.
- Reset mid-operation: `reset` has priority over every update in the same cycle. Stored memory contents are abandoned, and pointers restart at 0.
- Write latency: a push accepted at edge N is in memory after edge N. It is counted in `fifo_count` after edge N, and `empty` deasserts in cycle N+1.
- Read latency: a pop accepted in cycle N (addresses `read_addr`) captures data at edge N. `Fifo_Data_out` and `data_valid` are valid in cycle N+1.
- Read-during-write at the same address cannot occur: it would require empty (pop rejected) or full (push rejected) with equal pointers.
- Back-to-back push every cycle and pop every cycle are sustained at full throughput.

## Test plan
- Reset then idle: all outputs at reset values; `empty`=1, `almost_empty`=1, pointers 0.
- Fill: 8 pushes of 0x001..0x008.
  - `write_addr` steps 0..7 then wraps to 0.
  - `fifo_count` reaches 8 and `full`=1.
  - A 9th push leaves `write_addr`=0 and count 8, and sets `overflow`=1.
- Drain: 8 pops.
  - Memory output is 0x001..0x008 in order, each with `data_valid` one cycle after its pop.
  - `empty`=1 after the last pop.
  - A 9th pop sets `underflow`; `read_addr` stays 0.
- Thresholds with `umbral_alto`=6, `umbral_bajo`=2:
  - `almost_full` asserts exactly when count reaches 6.
  - `almost_empty` deasserts when count reaches 3.
- Simultaneous push & pop:
  - At count 4: count stays 4 and both pointers advance.
  - When empty: count → 1 and `underflow`=1.
  - When full: count → 7 and `overflow`=1.
- Reset asserted at count 5 with push high: next cycle count 0, pointers 0, flags cleared, `write_enable`=0 during reset.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a synchronous FIFO memory.
// Drives the memory's write/read ports and reports full/empty, threshold and sticky error flags.
module fifo_ctrl #(
  parameter int MEM_LENGHT = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [ADDR_WIDTH-1:0] fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  data_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_LENGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(MEM_LENGHT);

  // Flags derive only from the registered count, so push/pop never reach them combinationally.
  assign full         = (fifo_count == FULL_COUNT);
  assign empty        = (fifo_count == '0);
  assign almost_full  = (fifo_count >= umbral_alto);
  assign almost_empty = (fifo_count <= umbral_bajo);

  // Requests are suppressed during reset so the memory sees no stray access.
  assign write_enable = push & ~full  & ~reset;
  assign read_enable  = pop  & ~empty & ~reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_addr <= '0;
      read_addr  <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      if (write_enable)
        write_addr <= (write_addr == LAST_ADDR) ? '0 : write_addr + 1'b1;
      if (read_enable)
        read_addr <= (read_addr == LAST_ADDR) ? '0 : read_addr + 1'b1;

      unique case ({write_enable, read_enable})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (push && full)
        overflow <= 1'b1;
      if (pop && empty)
        underflow <= 1'b1;
      data_valid <= read_enable;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a small behavioural memory on its address/enable ports.
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
module tb_fifo_ctrl;

  localparam int MEM_LENGHT = 8;
  localparam int ADDR_WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] umbral_alto;
  logic [ADDR_WIDTH-1:0] umbral_bajo;
  logic                  write_enable;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [ADDR_WIDTH-1:0] fifo_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic                  data_valid;

  logic [11:0] write_data;
  logic [11:0] fifo_data_out;
  logic [11:0] mem [MEM_LENGHT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.MEM_LENGHT(MEM_LENGHT), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_addr   (write_addr),
    .read_addr    (read_addr),
    .fifo_count   (fifo_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .data_valid   (data_valid)
  );

  // Synchronous memory with registered read data.
  always @(posedge clk) begin
    if (write_enable) mem[write_addr] <= write_data;
    if (read_enable)  fifo_data_out   <= mem[read_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push = 1'b1; write_data = 12'(i + 1);
      tick();
    end
    push = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; write_data = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    tick();
    tick();

    // Reset blocks requests even with push/pop high.
    push = 1'b1; pop = 1'b1;
    #1;
    check("rst_we", write_enable, 0);
    check("rst_re", read_enable, 0);
    reset = 1'b0; push = 1'b0; pop = 1'b0;
    tick();
    check("rst_count", fifo_count, 0);
    check("rst_waddr", write_addr, 0);
    check("rst_raddr", read_addr, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_dv", data_valid, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    umbral_alto = 4'd0;
    #1;
    check("af_thr0", almost_full, 1);
    umbral_alto = 4'd6;

    // Fill with 1..8, watching the write pointer and threshold flags.
    for (int i = 0; i < MEM_LENGHT; i++) begin
      push = 1'b1; write_data = 12'(i + 1);
      #1;
      check("fill_waddr", write_addr, i);
      check("fill_we", write_enable, 1);
      tick();
      check("fill_count", fifo_count, i + 1);
      check("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
      check("fill_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
      check("fill_empty", empty, 0);
    end
    check("fill_full", full, 1);
    check("fill_wrap", write_addr, 0);
    check("fill_ovf0", overflow, 0);

    // Ninth push is rejected and flags overflow.
    write_data = 12'h0ff;
    #1;
    check("ovf_we", write_enable, 0);
    tick();
    push = 1'b0;
    check("ovf_waddr", write_addr, 0);
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", overflow, 1);

    // Drain; data arrives with data_valid one cycle after each pop.
    for (int i = 0; i < MEM_LENGHT; i++) begin
      pop = 1'b1;
      #1;
      check("drain_raddr", read_addr, i);
      check("drain_re", read_enable, 1);
      tick();
      check("drain_dv", data_valid, 1);
      check("drain_data", fifo_data_out, i + 1);
      check("drain_count", fifo_count, MEM_LENGHT - 1 - i);
    end
    check("drain_empty", empty, 1);
    check("drain_unf0", underflow, 0);

    // Ninth pop is rejected and flags underflow.
    #1;
    check("unf_re", read_enable, 0);
    tick();
    pop = 1'b0;
    check("unf_flag", underflow, 1);
    check("unf_raddr", read_addr, 0);
    check("unf_dv", data_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Simultaneous push/pop at count 4.
    do_reset();
    push_n(4);
    push = 1'b1; pop = 1'b1; write_data = 12'h055;
    tick();
    push = 1'b0; pop = 1'b0;
    check("sim4_count", fifo_count, 4);
    check("sim4_waddr", write_addr, 5);
    check("sim4_raddr", read_addr, 1);
    check("sim4_dv", data_valid, 1);
    check("sim4_data", fifo_data_out, 1);

    // Simultaneous push/pop when empty.
    do_reset();
    push = 1'b1; pop = 1'b1;
    tick();
    push = 1'b0; pop = 1'b0;
    check("sime_count", fifo_count, 1);
    check("sime_unf", underflow, 1);
    check("sime_raddr", read_addr, 0);

    // Simultaneous push/pop when full.
    do_reset();
    push_n(MEM_LENGHT);
    push = 1'b1; pop = 1'b1;
    tick();
    push = 1'b0; pop = 1'b0;
    check("simf_count", fifo_count, 7);
    check("simf_ovf", overflow, 1);
    check("simf_raddr", read_addr, 1);
    check("simf_waddr", write_addr, 0);

    // Down to 5, then reset with push held high.
    pop = 1'b1;
    tick();
    tick();
    pop = 1'b0;
    check("pre_rst_count", fifo_count, 5);
    reset = 1'b1; push = 1'b1;
    #1;
    check("midrst_we", write_enable, 0);
    tick();
    reset = 1'b0; push = 1'b0;
    check("midrst_count", fifo_count, 0);
    check("midrst_waddr", write_addr, 0);
    check("midrst_raddr", read_addr, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
